// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, FSM state encoding and datapath select encodings shared by the RV32I controllers
package riscv_pkg;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/aludec.sv
// aludec: maps ALUOp/funct3/op[5]/funct7b5 to the ALU control code
// ports: aluop, funct3, op5, funct7b5 in; alu_control out
module aludec
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);
  logic [2:0] funct_ctl;
  // only R-type (op[5]=1) may subtract; addi with imm[10]=1 must still add
  always_comb begin
    funct_ctl = funct3 == 3'b000 ? ((op5 & funct7b5) ? ALU_SUB : ALU_ADD) :
                funct3 == 3'b010 ? ALU_SLT :
                funct3 == 3'b100 ? ALU_XOR :
                funct3 == 3'b110 ? ALU_OR  :
                funct3 == 3'b111 ? ALU_AND : ALU_ADD;
    alu_control = aluop == ALUOP_SUB   ? ALU_SUB :
                  aluop == ALUOP_FUNCT ? funct_ctl : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM and decoders sequencing a shared-ALU, shared-memory RV32I datapath
// inputs: clk, reset, op, funct3, funct7b5, Zero
// outputs: PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite, State
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [2:0]         ImmSrc,
  output logic               RegWrite,
  output logic [STATE_W-1:0] State
);
  state_t state, next_state, st;
  logic [1:0] aluop;
  logic pcupdate, branch, irw, rw, mw, en;
  always_comb begin
    case (state)
      FETCH:                   next_state = DECODE;
      DECODE:                  next_state = (op == OP_LW || op == OP_SW) ? MEMADR :
                                            op == OP_R      ? EXECUTER :
                                            op == OP_I      ? EXECUTEI :
                                            op == OP_JAL    ? JAL      :
                                            op == OP_BRANCH ? BEQ      : FETCH;
      MEMADR:                  next_state = op == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:                 next_state = MEMWB;
      EXECUTER, EXECUTEI, JAL: next_state = ALUWB;
      default:                 next_state = FETCH;
    endcase
  end
  always_ff @(posedge clk) state <= reset ? FETCH : next_state;
  // during reset the selects show FETCH values while every enable is held low
  assign st = reset ? FETCH : state;
  assign en = ~reset;
  always_comb begin
    {pcupdate, branch, irw, rw, mw, AdrSrc} = '0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_RS2;
    aluop = ALUOP_ADD;
    case (st)
      FETCH:    begin irw = 1'b1; ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURES; pcupdate = 1'b1; end
      DECODE:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
      MEMADR:   begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = RES_MEM; rw = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; mw = 1'b1; end
      EXECUTER: begin ALUSrcA = SRCA_RS1; aluop = ALUOP_FUNCT; end
      EXECUTEI: begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; aluop = ALUOP_FUNCT; end
      ALUWB:    rw = 1'b1;
      JAL:      begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; pcupdate = 1'b1; end
      BEQ:      begin ALUSrcA = SRCA_RS1; aluop = ALUOP_SUB; branch = 1'b1; end
      default:  ;
    endcase
    // funct3[0] distinguishes bne from beq
    PCWrite = en & (pcupdate | (branch & (Zero ^ funct3[0])));
    IRWrite = en & irw;
    RegWrite = en & rw;
    MemWrite = en & mw;
  end
  assign ImmSrc = op == OP_SW ? IMM_S :
                  op == OP_BRANCH ? IMM_B :
                  op == OP_JAL ? IMM_J :
                  (op == OP_LUI || op == OP_AUIPC) ? IMM_U : IMM_I;
  assign State = STATE_W'(state);
  aludec u_aludec (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alu_control(ALUControl)
  );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed instruction sequences checked every cycle against a path/table model
module tb_multicycle_controller;
  typedef struct packed {
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu, imm;
    logic       rw;
  } outs_t;
  logic clk = 1'b0;
  logic reset, funct7b5, zero;
  logic [6:0] op;
  logic [2:0] funct3;
  logic pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb;
  logic [2:0] alucontrol, immsrc;
  logic [3:0] state;
  outs_t got, exp_o;
  int errors = 0, checks = 0, pos = 0, exp_s;
  logic go = 1'b0;
  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
    .PCWrite(pcwrite), .AdrSrc(adrsrc), .MemWrite(memwrite), .IRWrite(irwrite),
    .ResultSrc(resultsrc), .ALUSrcA(alusrca), .ALUSrcB(alusrcb), .ALUControl(alucontrol),
    .ImmSrc(immsrc), .RegWrite(regwrite), .State(state)
  );
  always #5 clk = ~clk;
  assign got = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, alucontrol, immsrc, regwrite};
  function automatic int path_len(input logic [6:0] o);
    case (o)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default: return 2;
    endcase
  endfunction
  function automatic int path_at(input logic [6:0] o, input int k);
    int p[5];
    case (o)
      7'b0000011: p = '{0, 1, 2, 3, 4};
      7'b0100011: p = '{0, 1, 2, 5, 0};
      7'b0110011: p = '{0, 1, 6, 7, 0};
      7'b0010011: p = '{0, 1, 8, 7, 0};
      7'b1101111: p = '{0, 1, 9, 7, 0};
      7'b1100011: p = '{0, 1, 10, 0, 0};
      default:    p = '{0, 1, 0, 0, 0};
    endcase
    return p[k];
  endfunction
  function automatic outs_t model(input int s, input logic rst, input logic [6:0] o,
                                  input logic [2:0] f3, input logic f7, input logic z);
    outs_t e = '0;
    logic en = !rst;
    logic [2:0] falu;
    if (rst) s = 0;
    e.imm = o == 7'b0100011 ? 3'd1 : o == 7'b1100011 ? 3'd2 : o == 7'b1101111 ? 3'd3 :
            (o == 7'b0110111 || o == 7'b0010111) ? 3'd4 : 3'd0;
    falu = f3 == 3'b000 ? ((o == 7'b0110011 && f7) ? 3'd1 : 3'd0) : f3 == 3'b010 ? 3'd5 :
           f3 == 3'b100 ? 3'd4 : f3 == 3'b110 ? 3'd3 : f3 == 3'b111 ? 3'd2 : 3'd0;
    case (s)
      0:  begin e.irw = en; e.sb = 2; e.rs = 2; e.pcw = en; end
      1:  begin e.sa = 1; e.sb = 1; end
      2:  begin e.sa = 2; e.sb = 1; end
      3:  e.adr = 1;
      4:  begin e.rs = 1; e.rw = en; end
      5:  begin e.adr = 1; e.mw = en; end
      6:  begin e.sa = 2; e.alu = falu; end
      7:  e.rw = en;
      8:  begin e.sa = 2; e.sb = 1; e.alu = falu; end
      9:  begin e.sa = 1; e.sb = 2; e.pcw = en; end
      10: begin e.sa = 2; e.alu = 3'd1; e.pcw = en & (z ^ f3[0]); end
      default: ;
    endcase
    return e;
  endfunction
  always @(posedge clk) pos <= reset ? 0 : (pos + 1 >= path_len(op) ? 0 : pos + 1);
  always @(negedge clk) if (go) begin
    exp_s = path_at(op, pos);
    checks++;
    if (state !== 4'(exp_s)) begin
      errors++;
      $display("FAIL state t=%0t got=%0d exp=%0d", $time, state, exp_s);
    end
    exp_o = model(exp_s, reset, op, funct3, funct7b5, zero);
    checks++;
    if (got !== exp_o) begin
      errors++;
      $display("FAIL outputs t=%0t state=%0d got=%h exp=%h", $time, state, got, exp_o);
    end
  end
  task automatic pin(input string name, input logic [3:0] g, input logic [3:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, g, e);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    set(o, f3, f7, z);
    step(path_len(o));
  endtask
  initial begin
    reset = 1'b1;
    set(7'b0000011, 3'b010, 1'b0, 1'b0);
    @(posedge clk);
    go = 1'b1;
    step(1);
    pin("reset_enables", {pcwrite, irwrite, regwrite, memwrite}, 4'h0);
    pin("reset_state", state, 4'd0);
    reset = 1'b0;
    step(4);
    pin("lw_memwb_state", state, 4'd4);
    pin("lw_memwb_regwrite", {3'b0, regwrite}, 4'h1);
    pin("lw_memwb_resultsrc", {2'b0, resultsrc}, 4'h1);
    step(1);
    pin("lw_back_fetch", state, 4'd0);
    set(7'b0100011, 3'b010, 1'b0, 1'b0);
    step(3);
    pin("sw_memwrite", {memwrite, adrsrc, immsrc[1:0]}, 4'b1101);
    step(1);
    set(7'b0110011, 3'b000, 1'b1, 1'b0);
    step(2);
    pin("r_sub", {1'b0, alucontrol}, 4'h1);
    step(2);
    set(7'b0110011, 3'b000, 1'b0, 1'b0);
    step(2);
    pin("r_add", {1'b0, alucontrol}, 4'h0);
    step(2);
    set(7'b0010011, 3'b000, 1'b1, 1'b0);
    step(2);
    pin("addi_never_sub", {1'b0, alucontrol}, 4'h0);
    step(2);
    run(7'b0110011, 3'b100, 1'b0, 1'b0);
    run(7'b0010011, 3'b010, 1'b0, 1'b0);
    run(7'b0110011, 3'b110, 1'b0, 1'b0);
    run(7'b0010011, 3'b111, 1'b0, 1'b0);
    run(7'b0110011, 3'b011, 1'b0, 1'b0);
    set(7'b1100011, 3'b000, 1'b0, 1'b1);
    step(2);
    pin("beq_taken", {3'b0, pcwrite}, 4'h1);
    step(1);
    set(7'b1100011, 3'b000, 1'b0, 1'b0);
    step(2);
    pin("beq_not_taken", {3'b0, pcwrite}, 4'h0);
    step(1);
    set(7'b1100011, 3'b001, 1'b0, 1'b1);
    step(2);
    pin("bne_zero", {3'b0, pcwrite}, 4'h0);
    step(1);
    pin("branch_latency", state, 4'd0);
    run(7'b1100011, 3'b001, 1'b0, 1'b0);
    set(7'b1101111, 3'b000, 1'b0, 1'b0);
    step(2);
    pin("jal_state", state, 4'd9);
    pin("jal_pcwrite", {3'b0, pcwrite}, 4'h1);
    step(1);
    pin("jal_aluwb_regwrite", {3'b0, regwrite}, 4'h1);
    step(1);
    set(7'b1111111, 3'b000, 1'b0, 1'b0);
    step(1);
    pin("illegal_decode", state, 4'd1);
    step(1);
    pin("illegal_back_fetch", state, 4'd0);
    run(7'b0110111, 3'b000, 1'b0, 1'b0);
    set(7'b0000011, 3'b010, 1'b0, 1'b0);
    step(3);
    pin("mid_memread", state, 4'd3);
    reset = 1'b1;
    #1;
    pin("mid_reset_enables", {pcwrite, irwrite, regwrite, memwrite}, 4'h0);
    step(1);
    pin("mid_reset_fetch", state, 4'd0);
    reset = 1'b0;
    run(7'b0000011, 3'b010, 1'b0, 1'b0);
    run(7'b0100011, 3'b010, 1'b0, 1'b0);
    @(negedge clk);
    go = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
